// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: exception codes, reset/handler addresses
// and the legal instruction-memory window, plus the fetch address check.
package if_stage_pkg;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF     = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF     = 32'h0000_6FFC;

    // Address error on load (instruction fetch): misaligned or outside IM.
    function automatic logic fetch_adel(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Architectural fetch PC register: exception redirect beats stall, otherwise the
// decode-supplied next PC is loaded unchanged.
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        stall_i,
    input  logic [31:0] npc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (req_i) begin
            pc_d = EXC_ENTRY;
        end else if (!stall_i) begin
            pc_d = npc_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register; flags fetch
// address errors and hands PC, instruction, exception code and delay-slot bit to ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] IM_LO     = IM_LO_DEF,
    parameter logic [31:0] IM_HI     = IM_HI_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        IF_ID_FLUSH,
    input  logic [31:0] ID_NPC,
    input  logic        ID_is_jump,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instr,
    output logic [4:0]  ID_ExcCode,
    output logic        ID_BD
);

    logic        adel;
    logic [31:0] if_instr;
    logic [4:0]  if_exc;

    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [4:0]  id_exc_q,   id_exc_d;
    logic        id_bd_q,    id_bd_d;

    if_stage_pc_reg #(
        .RESET_PC  (RESET_PC),
        .EXC_ENTRY (EXC_ENTRY)
    ) u_pc_reg (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (req),
        .stall_i (stall),
        .npc_i   (ID_NPC),
        .pc_o    (IF_PC)
    );

    assign i_inst_addr = IF_PC;

    // A faulting fetch carries a nop so nothing from the bad address executes.
    assign adel     = fetch_adel(IF_PC, IM_LO, IM_HI);
    assign if_instr = adel ? 32'h0 : i_inst_rdata;
    assign if_exc   = adel ? EXC_ADEL : EXC_NONE;

    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_exc_d   = id_exc_q;
        id_bd_d    = id_bd_q;
        if (req) begin
            id_pc_d    = EXC_ENTRY;
            id_instr_d = 32'h0;
            id_exc_d   = EXC_NONE;
            id_bd_d    = 1'b0;
        end else if (stall) begin
            id_pc_d    = id_pc_q;
        end else if (IF_ID_FLUSH) begin
            id_pc_d    = IF_PC;
            id_instr_d = 32'h0;
            id_exc_d   = EXC_NONE;
            id_bd_d    = 1'b0;
        end else begin
            id_pc_d    = IF_PC;
            id_instr_d = if_instr;
            id_exc_d   = if_exc;
            id_bd_d    = ID_is_jump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_pc_q    <= 32'h0;
            id_instr_q <= 32'h0;
            id_exc_q   <= EXC_NONE;
            id_bd_q    <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_exc_q   <= id_exc_d;
            id_bd_q    <= id_bd_d;
        end
    end

    assign ID_PC      = id_pc_q;
    assign ID_instr   = id_instr_q;
    assign ID_ExcCode = id_exc_q;
    assign ID_BD      = id_bd_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: each driven cycle pushes the expected next state,
// which is popped and compared one edge later.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req;
    logic        IF_ID_FLUSH;
    logic [31:0] ID_NPC;
    logic        ID_is_jump;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic [31:0] ID_instr;
    logic [4:0]  ID_ExcCode;
    logic        ID_BD;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] idpc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .req          (req),
        .IF_ID_FLUSH  (IF_ID_FLUSH),
        .ID_NPC       (ID_NPC),
        .ID_is_jump   (ID_is_jump),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .IF_PC        (IF_PC),
        .ID_PC        (ID_PC),
        .ID_instr     (ID_instr),
        .ID_ExcCode   (ID_ExcCode),
        .ID_BD        (ID_BD)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h3000: return 32'h2401_0001;
            32'h3004: return 32'h2402_0002;
            32'h3008: return 32'h2403_0003;
            default:  return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".IF_PC"},  IF_PC,              e.pc);
        chk({tag, ".addr"},   i_inst_addr,        e.pc);
        chk({tag, ".ID_PC"},  ID_PC,              e.idpc);
        chk({tag, ".instr"},  ID_instr,           e.instr);
        chk({tag, ".exc"},    {27'd0, ID_ExcCode}, {27'd0, e.exc});
        chk({tag, ".BD"},     {31'd0, ID_BD},     {31'd0, e.bd});
    endtask

    // Called at posedge+1: compute expectation from the model, drive, wait an edge, compare.
    task automatic step(input string tag, input logic s, input logic r, input logic f,
                        input logic j, input logic [31:0] npc);
        exp_t e;
        exp_t got;
        logic ad;
        e = m;
        if (r) begin
            e.pc = 32'h4180; e.idpc = 32'h4180; e.instr = 32'h0; e.exc = 5'd0; e.bd = 1'b0;
        end else if (!s) begin
            e.pc   = npc;
            e.idpc = m.pc;
            if (f) begin
                e.instr = 32'h0; e.exc = 5'd0; e.bd = 1'b0;
            end else begin
                ad = (m.pc[1:0] != 2'b00) || (m.pc < 32'h3000) || (m.pc > 32'h6FFC);
                e.instr = ad ? 32'h0 : mem_word(m.pc);
                e.exc   = ad ? 5'd4 : 5'd0;
                e.bd    = j;
            end
        end
        sb.push_back(e);
        stall = s; req = r; IF_ID_FLUSH = f; ID_is_jump = j; ID_NPC = npc;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk_all(tag, got);
        m = got;
    endtask

    task automatic nstep(input string tag, input logic j, input logic [31:0] npc);
        step(tag, 1'b0, 1'b0, 1'b0, j, npc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; req = 1'b0; IF_ID_FLUSH = 1'b0;
        ID_NPC = 32'h0; ID_is_jump = 1'b0;
        m = '{pc: 32'h3000, idpc: 32'h0, instr: 32'h0, exc: 5'd0, bd: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", m);
        reset = 1'b0;

        // Straight-line fetch
        nstep("seq0", 1'b0, m.pc + 32'd4);
        chk("seq0.pc", IF_PC, 32'h3004);
        chk("seq0.ins", ID_instr, 32'h2401_0001);
        nstep("seq1", 1'b0, m.pc + 32'd4);
        chk("seq1.idpc", ID_PC, 32'h3004);
        nstep("seq2", 1'b0, m.pc + 32'd4);
        chk("seq2.ins", ID_instr, 32'h2403_0003);

        // Branch in ID at 0x3008: delay slot 0x300C gets BD, target 0x3020 does not
        nstep("br0", 1'b1, 32'h3020);
        chk("br0.idpc", ID_PC, 32'h300C);
        chk("br0.bd", {31'd0, ID_BD}, 32'd1);
        nstep("br1", 1'b0, 32'h3024);
        chk("br1.idpc", ID_PC, 32'h3020);
        chk("br1.bd", {31'd0, ID_BD}, 32'd0);

        // Two-cycle stall, then resume without losing the held instruction
        step("stl0", 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000);
        step("stl1", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_0004);
        nstep("stl2", 1'b0, m.pc + 32'd4);
        chk("stl2.idpc", ID_PC, 32'h3024);

        // Fetch address errors: misaligned, above IM, below IM; top word is legal
        nstep("ad0", 1'b0, 32'h3002);
        nstep("ad1", 1'b0, 32'h7000);
        chk("ad1.exc", {27'd0, ID_ExcCode}, 32'd4);
        nstep("ad2", 1'b0, 32'h2FFC);
        chk("ad2.exc", {27'd0, ID_ExcCode}, 32'd4);
        nstep("ad3", 1'b0, 32'h6FFC);
        nstep("ad4", 1'b0, 32'h3100);
        chk("ad4.exc", {27'd0, ID_ExcCode}, 32'd0);
        chk("ad4.ins", ID_instr, 32'hC0DE_6FFC);

        // req wins over stall and flush
        step("req0", 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        chk("req0.pc", IF_PC, 32'h4180);
        nstep("req1", 1'b0, 32'h3404);
        chk("req1.idpc", ID_PC, 32'h4180);

        // eret flush: held by stall, then squashes and redirects to EPC
        step("fl0", 1'b1, 1'b0, 1'b1, 1'b1, 32'h3010);
        step("fl1", 1'b0, 1'b0, 1'b1, 1'b1, 32'h3010);
        chk("fl1.idpc", ID_PC, 32'h3404);
        chk("fl1.pc", IF_PC, 32'h3010);
        chk("fl1.ins", ID_instr, 32'h0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [31:0] npc;
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 7))
                0: npc = 32'h3002;
                1: npc = 32'h7000;
                2: npc = 32'h6FFC;
                3: npc = 32'h2FFC;
                default: npc = m.pc + 32'd4;
            endcase
            step("rnd", (r == 1) || (r == 2), r == 0, (r == 3) || (r == 2),
                 $urandom_range(0, 3) == 0, npc);
        end

        // Asynchronous reset mid-operation overrides a pending req
        req = 1'b1; stall = 1'b0; IF_ID_FLUSH = 1'b0;
        #2 reset = 1'b1;
        #1;
        m = '{pc: 32'h3000, idpc: 32'h0, instr: 32'h0, exc: 5'd0, bd: 1'b0};
        chk_all("areset", m);
        @(posedge clk);
        #1;
        chk_all("areset_hold", m);
        reset = 1'b0; req = 1'b0;
        nstep("post", 1'b0, 32'h3004);
        chk("post.ins", ID_instr, 32'h2401_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
